hour_counter_gen: RTL and testbench
===================================

Name: hour_counter_gen

Overview:
- Next-generation hour counter for the EDA digital clock; replaces the fixed 24/12 hour counter with a single-clock, parametrised block.
- Internal state is a binary hour, 0..23. The 12/24 h BCD display is derived from it, so toggling showMode never corrupts the time.
- Adds AM/PM, up/down setting with hold-to-repeat, direct load, day carry and an hourly chime.
- Sits between the minute counter's carry and the display/day logic.

Parameters:
- RESET_HOUR, 0: binary hour (0..23) loaded on reset.
- HOLD_CYCLES, 500: clk cycles a set button must stay held before auto-repeat starts.
- REPEAT_CYCLES, 100: clk cycles between auto-repeat steps.
- CNT_W, 16: width of the hold/repeat counter; must hold max(HOLD_CYCLES, REPEAT_CYCLES).
- CHIME_EN, 1: 1 enables hour_chime; 0 ties it low.

Ports:
- clk, input, 1: single system clock; all state changes on the rising edge.
- CLR_n, input, 1: asynchronous active-low reset.
- tick_in, input, 1: one-cycle minute-rollover pulse (59->00).
- showMode, input, 1: 0 = 24 h display, 1 = 12 h display.
- isSetting, input, 1: 1 = setting mode.
- set_inc, input, 1: debounced level of the increment button.
- set_dec, input, 1: debounced level of the decrement button.
- load_en, input, 1: one-cycle direct-load strobe.
- load_hour, input, 5: binary hour to load.
- hour_ten, output, 4: BCD tens of the displayed hour.
- hour_one, output, 4: BCD ones of the displayed hour.
- pm, output, 1: 1 when the internal hour is 12..23, in both display modes.
- hour_bin, output, 5: internal binary hour.
- day_carry, output, 1: one-cycle pulse on natural 23->0 rollover.
- hour_chime, output, 1: one-cycle pulse on every natural hour advance.

Behaviour:
- Reset (CLR_n=0, asynchronous):
  - h := RESET_HOUR.
  - hour_bin = RESET_HOUR; display registers hold RESET_HOUR formatted as for showMode=0 (24 h).
  - day_carry=0, hour_chime=0, repeat counter=0, edge-detect registers=0.
  - If CLR_n deasserts while a button is held, the held button yields no step (previous-state register must see the release first).
- Update priority per cycle, highest first:
  1. load_en=1: h := load_hour if load_hour <= 23; otherwise the load is ignored. Accepted in any mode.
  2. isSetting=1: apply a step from the button logic. tick_in is ignored; day_carry and hour_chime stay 0.
  3. isSetting=0 and tick_in=1: h := (h==23) ? 0 : h+1. Same cycle, registered: hour_chime=CHIME_EN, day_carry=(h==23).
- Button step logic (active only while isSetting=1):
  - Exactly one of set_inc/set_dec high; rising edge (registered previous level = 0): one step, counter cleared.
  - Still held: counter increments. On reaching HOLD_CYCLES, step and clear; thereafter step every REPEAT_CYCLES.
  - Increment wraps 23->0; decrement wraps 0->23. Setting wraps never raise day_carry.
  - Both buttons high, or neither: no step, counter cleared.
  - isSetting=0: counter held at 0; edge registers keep tracking the buttons, so a button held when setting mode opens does not step.
- Display, registered, 1 cycle after h or showMode changes:
  - showMode=0: value = h.
  - showMode=1: h==0 -> 12; 1..12 -> h; 13..23 -> h-12.
  - hour_ten/hour_one = BCD of value (tens 0..2).
  - pm = (h>=12), registered with the display.
- hour_bin reflects h with no extra delay.
- day_carry and hour_chime are exactly one cycle wide.
- Out-of-range values (>23) are unreachable.

Test Plan:
- RESET_HOUR=0: reset, then 24 tick_in pulses -> hour_bin steps 1..23,0; day_carry high only on the 24th; hour_chime on all 24.
- load_hour=13, showMode=1 -> next cycle 01, pm=1. Toggle showMode=0 -> 13, hour_bin unchanged. load_hour=0 -> 12, pm=0.
- isSetting=1, h=0: one set_dec edge -> h=23, day_carry=0. Concurrent tick_in pulses -> no change.
- HOLD_CYCLES=4, REPEAT_CYCLES=2: set_inc held 10 cycles from h=5 -> steps at edge, +4, +6, +8 cycles; h=9.
- set_inc and set_dec both high -> no step. load_en with load_hour=24 -> h unchanged. load_en concurrent with tick_in -> load wins.
- Assert CLR_n low mid-repeat with h=7 -> immediate h=RESET_HOUR, all pulses 0; after release with the button still held -> no step.

Source files
------------

// File: rtl/hour_counter_gen.sv
// Hour counter for the digital clock: binary hour 0..23 with 12/24 h BCD display,
// AM/PM, up/down setting with hold-to-repeat, direct load, day carry and hourly chime.
module hour_counter_gen #(
    parameter int unsigned RESET_HOUR    = 0,
    parameter int unsigned HOLD_CYCLES   = 500,
    parameter int unsigned REPEAT_CYCLES = 100,
    parameter int unsigned CNT_W         = 16,
    parameter int unsigned CHIME_EN      = 1
) (
    input  logic       clk,
    input  logic       CLR_n,
    input  logic       tick_in,
    input  logic       showMode,
    input  logic       isSetting,
    input  logic       set_inc,
    input  logic       set_dec,
    input  logic       load_en,
    input  logic [4:0] load_hour,
    output logic [3:0] hour_ten,
    output logic [3:0] hour_one,
    output logic       pm,
    output logic [4:0] hour_bin,
    output logic       day_carry,
    output logic       hour_chime
);

    localparam logic [4:0]       ResetHour = 5'(RESET_HOUR);
    localparam logic [CNT_W-1:0] HoldCnt   = CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] RepeatCnt = CNT_W'(REPEAT_CYCLES);
    localparam logic             ChimeOn   = (CHIME_EN != 0);

    // Returns {tens, ones} of the hour as shown in the selected display mode.
    function automatic logic [7:0] fmt_hour(input logic [4:0] h, input logic mode12);
        logic [4:0] v;
        logic [3:0] ten;
        logic [3:0] one;
        v = h;
        if (mode12) begin
            if (h == 5'd0) begin
                v = 5'd12;
            end else if (h > 5'd12) begin
                v = h - 5'd12;
            end
        end
        if (v >= 5'd20) begin
            ten = 4'd2;
            one = 4'(v - 5'd20);
        end else if (v >= 5'd10) begin
            ten = 4'd1;
            one = 4'(v - 5'd10);
        end else begin
            ten = 4'd0;
            one = 4'(v);
        end
        return {ten, one};
    endfunction

    localparam logic [7:0] ResetDisp = fmt_hour(ResetHour, 1'b0);

    logic [4:0]       h_q, h_d;
    logic [7:0]       disp_q, disp_d;
    logic             pm_q, pm_d;
    logic             carry_q, carry_d;
    logic             chime_q, chime_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rep_q, rep_d;
    logic             inc_prev_q, dec_prev_q;
    logic             inc_arm_q, dec_arm_q;

    logic             inc_lvl, dec_lvl;
    logic             one_btn, btn_edge;
    logic [CNT_W-1:0] cnt_inc;
    logic             step;
    logic [4:0]       h_inc, h_dec;

    // A button only counts once it has been seen released since reset, so a
    // button held through reset never produces a step.
    assign inc_lvl  = set_inc & inc_arm_q;
    assign dec_lvl  = set_dec & dec_arm_q;
    assign one_btn  = inc_lvl ^ dec_lvl;
    assign btn_edge = (inc_lvl & ~inc_prev_q) | (dec_lvl & ~dec_prev_q);
    assign cnt_inc  = cnt_q + CNT_W'(1);

    assign h_inc = (h_q == 5'd23) ? 5'd0 : h_q + 5'd1;
    assign h_dec = (h_q == 5'd0) ? 5'd23 : h_q - 5'd1;

    // Hold/repeat timing: rep_q selects the initial hold interval or the repeat interval.
    always_comb begin
        cnt_d = '0;
        rep_d = 1'b0;
        step  = 1'b0;
        if (isSetting && one_btn) begin
            if (btn_edge) begin
                step = 1'b1;
            end else begin
                cnt_d = cnt_inc;
                rep_d = rep_q;
                if (cnt_inc == (rep_q ? RepeatCnt : HoldCnt)) begin
                    step  = 1'b1;
                    cnt_d = '0;
                    rep_d = 1'b1;
                end
            end
        end
    end

    always_comb begin
        h_d     = h_q;
        carry_d = 1'b0;
        chime_d = 1'b0;
        if (load_en) begin
            if (load_hour <= 5'd23) begin
                h_d = load_hour;
            end
        end else if (isSetting) begin
            if (step) begin
                h_d = inc_lvl ? h_inc : h_dec;
            end
        end else if (tick_in) begin
            h_d     = h_inc;
            chime_d = ChimeOn;
            carry_d = (h_q == 5'd23);
        end
    end

    always_comb begin
        disp_d = fmt_hour(h_q, showMode);
        pm_d   = (h_q >= 5'd12);
    end

    always_ff @(posedge clk or negedge CLR_n) begin
        if (!CLR_n) begin
            h_q        <= ResetHour;
            disp_q     <= ResetDisp;
            pm_q       <= (ResetHour >= 5'd12);
            carry_q    <= 1'b0;
            chime_q    <= 1'b0;
            cnt_q      <= '0;
            rep_q      <= 1'b0;
            inc_prev_q <= 1'b0;
            dec_prev_q <= 1'b0;
            inc_arm_q  <= 1'b0;
            dec_arm_q  <= 1'b0;
        end else begin
            h_q        <= h_d;
            disp_q     <= disp_d;
            pm_q       <= pm_d;
            carry_q    <= carry_d;
            chime_q    <= chime_d;
            cnt_q      <= cnt_d;
            rep_q      <= rep_d;
            inc_prev_q <= set_inc;
            dec_prev_q <= set_dec;
            inc_arm_q  <= inc_arm_q | ~set_inc;
            dec_arm_q  <= dec_arm_q | ~set_dec;
        end
    end

    assign hour_bin   = h_q;
    assign hour_ten   = disp_q[7:4];
    assign hour_one   = disp_q[3:0];
    assign pm         = pm_q;
    assign day_carry  = carry_q;
    assign hour_chime = chime_q;

endmodule

// File: tb/tb_hour_counter_gen.sv
// Self-checking bench for hour_counter_gen: cycle model compared every cycle plus
// directed literal expectations.
module tb_hour_counter_gen;

    localparam int Hold   = 4;
    localparam int Repeat = 2;
    localparam int RstH   = 0;

    logic       clk;
    logic       CLR_n;
    logic       tick_in, showMode, isSetting, set_inc, set_dec, load_en;
    logic [4:0] load_hour;
    logic [3:0] hour_ten, hour_one;
    logic       pm, day_carry, hour_chime;
    logic [4:0] hour_bin;

    int checks = 0;
    int errors = 0;

    hour_counter_gen #(
        .RESET_HOUR   (RstH),
        .HOLD_CYCLES  (Hold),
        .REPEAT_CYCLES(Repeat),
        .CNT_W        (16),
        .CHIME_EN     (1)
    ) dut (
        .clk       (clk),
        .CLR_n     (CLR_n),
        .tick_in   (tick_in),
        .showMode  (showMode),
        .isSetting (isSetting),
        .set_inc   (set_inc),
        .set_dec   (set_dec),
        .load_en   (load_en),
        .load_hour (load_hour),
        .hour_ten  (hour_ten),
        .hour_one  (hour_one),
        .pm        (pm),
        .hour_bin  (hour_bin),
        .day_carry (day_carry),
        .hour_chime(hour_chime)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Displayed value as the clock face shows it.
    function automatic int shown(input int h, input logic mode12);
        if (!mode12) return h;
        if (h == 0) return 12;
        if (h > 12) return h - 12;
        return h;
    endfunction

    // Behavioural model
    int m_h, m_ten, m_one, m_k;
    bit m_pm, m_carry, m_chime, m_pinc, m_pdec, m_arm_inc, m_arm_dec;

    always @(posedge clk or negedge CLR_n) begin
        int  v, nh, k;
        bit  a, b, stp;
        if (!CLR_n) begin
            m_h       <= RstH;
            m_ten     <= RstH / 10;
            m_one     <= RstH % 10;
            m_pm      <= (RstH >= 12);
            m_carry   <= 0;
            m_chime   <= 0;
            m_k       <= 0;
            m_pinc    <= 0;
            m_pdec    <= 0;
            m_arm_inc <= 0;
            m_arm_dec <= 0;
        end else begin
            v = shown(m_h, showMode);
            m_ten <= v / 10;
            m_one <= v % 10;
            m_pm  <= (m_h >= 12);
            a = set_inc && m_arm_inc;
            b = set_dec && m_arm_dec;
            stp = 0;
            k = 0;
            // k counts cycles since the press; steps at 0, Hold, Hold+Repeat, ...
            if (isSetting && (a != b)) begin
                if ((a && !m_pinc) || (b && !m_pdec)) k = 0;
                else k = m_k + 1;
                stp = (k == 0) || (k >= Hold && ((k - Hold) % Repeat) == 0);
            end
            m_k <= k;
            nh = m_h;
            m_carry <= 0;
            m_chime <= 0;
            if (load_en) begin
                if (load_hour <= 23) nh = load_hour;
            end else if (isSetting) begin
                if (stp) nh = a ? (m_h + 1) % 24 : (m_h + 23) % 24;
            end else if (tick_in) begin
                m_carry <= (m_h == 23);
                m_chime <= 1;
                nh = (m_h + 1) % 24;
            end
            m_h    <= nh;
            m_pinc <= set_inc;
            m_pdec <= set_dec;
            if (!set_inc) m_arm_inc <= 1;
            if (!set_dec) m_arm_dec <= 1;
        end
    end

    always @(negedge clk) begin
        chk("hour_bin", int'(hour_bin), m_h);
        chk("hour_ten", int'(hour_ten), m_ten);
        chk("hour_one", int'(hour_one), m_one);
        chk("pm", int'(pm), int'(m_pm));
        chk("day_carry", int'(day_carry), int'(m_carry));
        chk("hour_chime", int'(hour_chime), int'(m_chime));
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_load(input int h);
        load_en = 1;
        load_hour = 5'(h);
        cyc(1);
        load_en = 0;
    endtask

    int exp_hold[10] = '{6, 6, 6, 6, 7, 7, 8, 8, 9, 9};

    initial begin
        CLR_n = 0;
        tick_in = 0; showMode = 0; isSetting = 0;
        set_inc = 0; set_dec = 0; load_en = 0; load_hour = 0;
        cyc(2);
        chk("rst_bin", int'(hour_bin), 0);
        chk("rst_ten", int'(hour_ten), 0);
        chk("rst_one", int'(hour_one), 0);
        chk("rst_carry", int'(day_carry), 0);
        chk("rst_chime", int'(hour_chime), 0);
        CLR_n = 1;
        cyc(1);

        // 24 natural hour advances
        for (int i = 1; i <= 24; i++) begin
            tick_in = 1;
            cyc(1);
            tick_in = 0;
            chk("tick_bin", int'(hour_bin), i % 24);
            chk("tick_carry", int'(day_carry), (i == 24) ? 1 : 0);
            chk("tick_chime", int'(hour_chime), 1);
            cyc(1);
            chk("chime_width", int'(hour_chime), 0);
        end

        // 12 h display and mode toggle
        showMode = 1;
        do_load(13);
        chk("load13_bin", int'(hour_bin), 13);
        cyc(1);
        chk("12h_ten", int'(hour_ten), 0);
        chk("12h_one", int'(hour_one), 1);
        chk("12h_pm", int'(pm), 1);
        showMode = 0;
        cyc(1);
        chk("24h_ten", int'(hour_ten), 1);
        chk("24h_one", int'(hour_one), 3);
        chk("24h_bin", int'(hour_bin), 13);
        showMode = 1;
        do_load(0);
        cyc(1);
        chk("midnight_ten", int'(hour_ten), 1);
        chk("midnight_one", int'(hour_one), 2);
        chk("midnight_pm", int'(pm), 0);

        // Setting: decrement wraps 0->23 without day carry; ticks ignored
        isSetting = 1;
        set_dec = 1;
        cyc(1);
        chk("dec_wrap", int'(hour_bin), 23);
        chk("dec_carry", int'(day_carry), 0);
        set_dec = 0;
        cyc(1);
        tick_in = 1;
        cyc(3);
        tick_in = 0;
        chk("set_tick_bin", int'(hour_bin), 23);
        chk("set_tick_chime", int'(hour_chime), 0);

        // Hold-to-repeat from 5
        do_load(5);
        chk("load5", int'(hour_bin), 5);
        set_inc = 1;
        for (int j = 0; j < 10; j++) begin
            cyc(1);
            chk("hold_seq", int'(hour_bin), exp_hold[j]);
        end
        set_inc = 0;
        cyc(1);
        chk("hold_end", int'(hour_bin), 9);

        // Both buttons: no step
        set_inc = 1;
        set_dec = 1;
        cyc(6);
        chk("both_btn", int'(hour_bin), 9);
        set_inc = 0;
        set_dec = 0;
        cyc(1);

        // Out-of-range load ignored
        do_load(24);
        chk("load24", int'(hour_bin), 9);

        // Load beats tick
        isSetting = 0;
        tick_in = 1;
        do_load(3);
        tick_in = 0;
        chk("load_vs_tick", int'(hour_bin), 3);
        chk("load_vs_chime", int'(hour_chime), 0);

        // Async reset mid-repeat with button held through release
        isSetting = 1;
        do_load(6);
        set_inc = 1;
        cyc(1);
        chk("pre_rst", int'(hour_bin), 7);
        cyc(2);
        #2 CLR_n = 0;
        #1;
        chk("async_bin", int'(hour_bin), RstH);
        chk("async_carry", int'(day_carry), 0);
        chk("async_chime", int'(hour_chime), 0);
        chk("async_one", int'(hour_one), 0);
        cyc(1);
        CLR_n = 1;
        cyc(12);
        chk("held_thru_rst", int'(hour_bin), RstH);
        set_inc = 0;
        cyc(1);
        set_inc = 1;
        cyc(1);
        chk("after_release", int'(hour_bin), RstH + 1);
        set_inc = 0;
        cyc(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
